red_seq: RTL

Iterative reduction sequencer for the RED instruction in the execute stage. It accepts two 16-bit operands through a valid/ready handshake and treats them as eight signed 4-bit nibbles. It sums the nibbles serially through a single shared 7-bit adder and returns the sign-extended 16-bit sum. It trades the combinational adder tree for an 8-cycle sequenced datapath, with backpressure on the result and a pipeline-flush abort.

---
 rtl/red_pkg.sv | 21 ++
 rtl/red_acc_add.sv | 14 +
 rtl/red_seq.sv | 101 ++++++++++
 3 files changed

// File: rtl/red_pkg.sv
// Shared types, widths and helpers for the RED reduction sequencer.
// Imported by the sequencer top and its accumulator adder.
`timescale 1ns/1ps
package red_pkg;

    localparam int NIB_W  = 4;
    localparam int ACC_W  = 7;
    localparam int CNT_W  = 3;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [ACC_W-1:0] sext_nib(input logic [NIB_W-1:0] nib);
        return {{(ACC_W-NIB_W){nib[NIB_W-1]}}, nib};
    endfunction

endpackage

// File: rtl/red_acc_add.sv
// Shared 7-bit two's-complement adder; the sequencer reuses it once per nibble.
// Carry-out is dropped: the accumulator range already covers every legal sum.
`timescale 1ns/1ps
module red_acc_add
    import red_pkg::*;
(
    input  logic [ACC_W-1:0] i_acc,
    input  logic [ACC_W-1:0] i_nib,
    output logic [ACC_W-1:0] o_sum
);

    assign o_sum = i_acc + i_nib;

endmodule

// File: rtl/red_seq.sv
// Iterative reduction sequencer: sums the eight signed nibbles of two 16-bit
// operands through one shared adder and returns the sign-extended total.
`timescale 1ns/1ps
module red_seq
    import red_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] r,
    output logic              busy
);

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_op_a;
    logic [DATA_W-1:0]  r_op_b;

    logic [DATA_W-1:0]  w_op_sel;
    logic [NIB_W-1:0]   w_nib;
    logic [ACC_W-1:0]   w_nib_ext;
    logic [ACC_W-1:0]   w_sum;
    logic               w_last;

    // cnt[0] alternates A/B, cnt[2:1] walks the nibble position low to high.
    assign w_op_sel = r_cnt[0] ? r_op_b : r_op_a;

    always_comb begin
        w_nib = '0;
        case (r_cnt[2:1])
            2'd0:    w_nib = w_op_sel[3:0];
            2'd1:    w_nib = w_op_sel[7:4];
            2'd2:    w_nib = w_op_sel[11:8];
            default: w_nib = w_op_sel[15:12];
        endcase
    end

    assign w_nib_ext = sext_nib(w_nib);
    assign w_last    = (r_cnt == {CNT_W{1'b1}});

    red_acc_add u_acc_add (
        .i_acc (r_acc),
        .i_nib (w_nib_ext),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_op_a  <= '0;
            r_op_b  <= '0;
        end else if (flush) begin
            // A flushed result is simply dropped, even if out_ready is high.
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_op_a  <= a;
                        r_op_b  <= b;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign r         = {{(DATA_W-ACC_W){r_acc[ACC_W-1]}}, r_acc};

endmodule
